alu_cmd_driver: RTL and testbench
=================================

ALU_CMD_DRIVER -- requirements
Module: alu_cmd_driver

Interface
REQ-001 SHALL have parameter BITS, default 16, operand and result width.
REQ-002 SHALL have parameter DEPTH, default 4, command FIFO entries (power of two).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port cmd_valid  input  1  command offered.
REQ-006 SHALL have port cmd_ready  output  1  command FIFO can accept.
REQ-007 SHALL have port cmd_a  input  BITS  operand A.
REQ-008 SHALL have port cmd_b  input  BITS  operand B.
REQ-009 SHALL have port cmd_op  input  3  ALU opcode (ADD, SUB, MULT, SHIFT_LEFT, AND, OR, XOR, NOT encodings), forwarded unmodified.
REQ-010 SHALL have ports alu_a, alu_b  output  BITS  operands to ALU; alu_opcode  output  3  opcode to ALU.
REQ-011 SHALL have port alu_rst  output  1  reset to ALU.
REQ-012 SHALL have port alu_out  input  BITS  ALU registered result; alu_status  input  1  ALU error flag (1 = ERROR).
REQ-013 SHALL have ports rsp_valid  output  1, rsp_ready  input  1, rsp_data  output  BITS, rsp_op  output  3, rsp_err  output  1.
REQ-014 SHALL have port busy  output  1  high whenever state is not IDLE or FIFO is non-empty.
REQ-015 SHALL have port err_count  output  8  count of ALU errors seen.

Function
REQ-016 SHALL accept a command on a rising edge with cmd_valid && cmd_ready; cmd_ready = !full (combinational from occupancy).
REQ-017 SHALL, with FIFO full, ignore cmd_valid; a simultaneous pop does not admit a push that cycle.
REQ-018 SHALL implement FSM states IDLE, ISSUE, CAPTURE, RECOVER, RESPOND.
REQ-019 IDLE: if FIFO non-empty, pop head, register it onto alu_a/alu_b/alu_opcode and rsp_op, go ISSUE; else stay.
REQ-020 ISSUE: hold ALU inputs for exactly one cycle (ALU clocks them at end of cycle), go CAPTURE.
REQ-021 CAPTURE: sample alu_out/alu_status; status 0 -> rsp_data = alu_out, rsp_err = 0, go RESPOND; status 1 -> rsp_data = 0, rsp_err = 1, go RECOVER.
REQ-022 RECOVER: assert alu_rst for exactly one cycle, increment err_count saturating at 255, go RESPOND.
REQ-023 RESPOND: rsp_valid = 1; rsp_data/rsp_op/rsp_err SHALL stay stable until rsp_valid && rsp_ready on an edge, then go IDLE.
REQ-024 alu_a/alu_b/alu_opcode SHALL retain their last values outside ISSUE.
REQ-025 Latency: push at edge E into empty FIFO in IDLE -> rsp_valid high after edge E+3 (no error) or E+4 (error).
REQ-026 FIFO pointers SHALL wrap modulo DEPTH; occupancy counter width log2(DEPTH)+1.
REQ-027 Pushes SHALL continue while FSM is in any state; only one command in flight at a time.

Reset
REQ-028 While rst = 1: state IDLE, FIFO empty, cmd_ready 1, rsp_valid 0, rsp_data 0, rsp_op 0, rsp_err 0, alu_a/alu_b/alu_opcode 0, err_count 0, busy 0.
REQ-029 alu_rst SHALL equal rst OR (state == RECOVER), so ALU is reset with this block.
REQ-030 Reset asserted mid-operation (any state) SHALL abort the in-flight command and discard all queued commands; no response issued for them.

Verification
REQ-031 Reset, push ADD A=33 B=45, rsp_ready=1 -> rsp_valid at E+3, rsp_data 78, rsp_err 0, rsp_op = ADD.
REQ-032 Push MULT A=9999 B=9999 -> alu_status 1 in CAPTURE, alu_rst pulses one cycle, rsp_err 1, rsp_data 0, err_count 1; next ADD 1+1 returns 2, rsp_err 0.
REQ-033 rsp_ready=0, push SUB 64-30, AND 3855&13107, OR, XOR, NOT, SHIFT_LEFT 10<<1 back-to-back -> cmd_ready drops after FIFO fills (one in flight + 4 queued); release rsp_ready -> responses in order 34, 771, 16191, 15420, 61680, 20; rsp_data stable while stalled.
REQ-034 Force 256 error commands -> err_count saturates at 255.
REQ-035 Assert rst during CAPTURE with 3 queued commands -> all outputs at reset values, alu_rst high, no responses after release, busy 0.

Source files
------------

// File: rtl/alu_cmd_driver.sv
// ---------------------------------------------------------------------------
// alu_cmd_driver
//
// Purpose:
//   Queues ALU commands in a small FIFO and drives them one at a time into an
//   external registered ALU. Each command is issued for one cycle, its result
//   is captured, and a response is offered on a valid/ready interface. An ALU
//   error flag produces an error response, pulses the ALU reset for one cycle
//   and bumps a saturating error counter.
//
// Ports:
//   clk         in   single clock, all state changes on rising edge
//   rst         in   asynchronous active-high reset
//   cmd_valid   in   command offered
//   cmd_ready   out  command FIFO can accept (not full)
//   cmd_a/b     in   operands, BITS wide
//   cmd_op      in   3-bit opcode, forwarded unmodified to the ALU
//   alu_a/b     out  operands to the ALU
//   alu_opcode  out  opcode to the ALU
//   alu_rst     out  ALU reset (rst, or one cycle after an ALU error)
//   alu_out     in   ALU registered result
//   alu_status  in   ALU error flag (1 = error)
//   rsp_valid   out  response offered
//   rsp_ready   in   response accepted
//   rsp_data    out  result (0 on error)
//   rsp_op      out  opcode of the command being answered
//   rsp_err     out  response is an error
//   busy        out  FSM not idle or FIFO not empty
//   err_count   out  number of ALU errors seen, saturating at 255
// ---------------------------------------------------------------------------
module alu_cmd_driver #(
    parameter int BITS  = 16,
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,

    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [BITS-1:0] cmd_a,
    input  logic [BITS-1:0] cmd_b,
    input  logic [2:0]      cmd_op,

    output logic [BITS-1:0] alu_a,
    output logic [BITS-1:0] alu_b,
    output logic [2:0]      alu_opcode,
    output logic            alu_rst,
    input  logic [BITS-1:0] alu_out,
    input  logic            alu_status,

    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [BITS-1:0] rsp_data,
    output logic [2:0]      rsp_op,
    output logic            rsp_err,

    output logic            busy,
    output logic [7:0]      err_count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0]   C_FULL    = (AW + 1)'(DEPTH);
    localparam logic [AW-1:0] C_LAST    = AW'(DEPTH - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ISSUE   = 3'd1,
        S_CAPTURE = 3'd2,
        S_RECOVER = 3'd3,
        S_RESPOND = 3'd4
    } state_t;

    state_t r_state;
    state_t w_next_state;

    // FIFO storage and bookkeeping
    logic [BITS-1:0] r_mem_a  [DEPTH];
    logic [BITS-1:0] r_mem_b  [DEPTH];
    logic [2:0]      r_mem_op [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [AW:0]     r_count;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;

    // Registered outputs
    logic [BITS-1:0] r_alu_a;
    logic [BITS-1:0] r_alu_b;
    logic [2:0]      r_alu_opcode;
    logic [BITS-1:0] r_rsp_data;
    logic [2:0]      r_rsp_op;
    logic            r_rsp_err;
    logic [7:0]      r_err_count;

    assign w_full  = (r_count == C_FULL);
    assign w_empty = (r_count == '0);
    // Readiness is purely occupancy based, so a pop in the same cycle never
    // opens room for a push when the FIFO is full.
    assign w_push  = cmd_valid && !w_full;
    // Only one command in flight: the head is popped only from IDLE.
    assign w_pop   = (r_state == S_IDLE) && !w_empty;

    // -----------------------------------------------------------------------
    // FIFO storage (contents need no reset, occupancy guards them)
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_a[r_wr_ptr]  <= cmd_a;
            r_mem_b[r_wr_ptr]  <= cmd_b;
            r_mem_op[r_wr_ptr] <= cmd_op;
        end
    end

    // -----------------------------------------------------------------------
    // FIFO pointers and occupancy
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == C_LAST) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == C_LAST) ? '0 : r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // FSM state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // -----------------------------------------------------------------------
    // FSM next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_next_state = S_ISSUE;
                end
            end
            S_ISSUE: begin
                // The ALU registers its inputs at the end of this cycle.
                w_next_state = S_CAPTURE;
            end
            S_CAPTURE: begin
                w_next_state = alu_status ? S_RECOVER : S_RESPOND;
            end
            S_RECOVER: begin
                w_next_state = S_RESPOND;
            end
            S_RESPOND: begin
                if (rsp_ready) begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // ALU drive registers: loaded on pop, held otherwise
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_alu_opcode <= '0;
            r_rsp_op     <= '0;
        end else if (w_pop) begin
            r_alu_a      <= r_mem_a[r_rd_ptr];
            r_alu_b      <= r_mem_b[r_rd_ptr];
            r_alu_opcode <= r_mem_op[r_rd_ptr];
            r_rsp_op     <= r_mem_op[r_rd_ptr];
        end
    end

    // -----------------------------------------------------------------------
    // Response capture; held through RESPOND until the handshake
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rsp_data <= '0;
            r_rsp_err  <= 1'b0;
        end else if (r_state == S_CAPTURE) begin
            r_rsp_data <= alu_status ? '0 : alu_out;
            r_rsp_err  <= alu_status;
        end
    end

    // -----------------------------------------------------------------------
    // Saturating error counter, bumped once per error in RECOVER
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_count <= '0;
        end else if ((r_state == S_RECOVER) && (r_err_count != 8'hFF)) begin
            r_err_count <= r_err_count + 8'd1;
        end
    end

    assign cmd_ready  = !w_full;
    assign alu_a      = r_alu_a;
    assign alu_b      = r_alu_b;
    assign alu_opcode = r_alu_opcode;
    // The ALU is reset together with this block and for the single RECOVER
    // cycle after an error.
    assign alu_rst    = rst || (r_state == S_RECOVER);
    assign rsp_valid  = (r_state == S_RESPOND);
    assign rsp_data   = r_rsp_data;
    assign rsp_op     = r_rsp_op;
    assign rsp_err    = r_rsp_err;
    assign busy       = (r_state != S_IDLE) || !w_empty;
    assign err_count  = r_err_count;

endmodule

// File: tb/tb_alu_cmd_driver.sv
module tb_alu_cmd_driver;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_MULT = 3'd2;
    localparam logic [2:0] OP_SHL  = 3'd3;
    localparam logic [2:0] OP_AND  = 3'd4;
    localparam logic [2:0] OP_OR   = 3'd5;
    localparam logic [2:0] OP_XOR  = 3'd6;
    localparam logic [2:0] OP_NOT  = 3'd7;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [15:0] cmd_a = '0;
    logic [15:0] cmd_b = '0;
    logic [2:0]  cmd_op = '0;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [2:0]  alu_opcode;
    logic        alu_rst;
    logic [15:0] alu_out;
    logic        alu_status;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [15:0] rsp_data;
    logic [2:0]  rsp_op;
    logic        rsp_err;
    logic        busy;
    logic [7:0]  err_count;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    alu_cmd_driver #(.BITS(16), .DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode), .alu_rst(alu_rst),
        .alu_out(alu_out), .alu_status(alu_status),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_op(rsp_op), .rsp_err(rsp_err),
        .busy(busy), .err_count(err_count)
    );

    // Registered ALU stand-in: MULT that overflows 16 bits flags an error.
    logic [31:0] m_prod;
    logic [15:0] m_res;
    logic        m_err;
    always_comb begin
        m_prod = {16'd0, alu_a} * {16'd0, alu_b};
        m_err  = 1'b0;
        case (alu_opcode)
            OP_ADD:  m_res = alu_a + alu_b;
            OP_SUB:  m_res = alu_a - alu_b;
            OP_MULT: begin m_res = m_prod[15:0]; m_err = |m_prod[31:16]; end
            OP_SHL:  m_res = alu_a << 1;
            OP_AND:  m_res = alu_a & alu_b;
            OP_OR:   m_res = alu_a | alu_b;
            OP_XOR:  m_res = alu_a ^ alu_b;
            default: m_res = ~alu_a;
        endcase
    end
    always_ff @(posedge clk) begin
        if (alu_rst) begin
            alu_out    <= '0;
            alu_status <= 1'b0;
        end else begin
            alu_out    <= m_res;
            alu_status <= m_err;
        end
    end

    // Offer one command; returns 1ns after the edge that accepted it.
    task automatic push(input logic [15:0] a, input logic [15:0] b, input logic [2:0] op);
        int n;
        cmd_a = a; cmd_b = b; cmd_op = op; cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        if (!cmd_ready) begin
            vectors++; miscompares++;
            $display("FAIL push_timeout: cmd_ready got %0b required 1", cmd_ready);
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    // Wait for a response, check it, then complete the handshake.
    task automatic expect_rsp(input string name, input logic [15:0] data,
                              input logic [2:0] op, input logic err);
        int n;
        n = 0;
        while (!rsp_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (!rsp_valid) begin
            miscompares++;
            $display("FAIL %s_timeout: rsp_valid got 0 required 1", name);
            return;
        end
        vectors += 3;
        if (rsp_data !== data) begin
            miscompares++;
            $display("FAIL %s_data: got %0d required %0d", name, rsp_data, data);
        end
        if (rsp_op !== op) begin
            miscompares++;
            $display("FAIL %s_op: got %0d required %0d", name, rsp_op, op);
        end
        if (rsp_err !== err) begin
            miscompares++;
            $display("FAIL %s_err: got %0b required %0b", name, rsp_err, err);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    task automatic check_reset_values(input string name);
        vectors += 6;
        if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL %s_ctrl: ready/valid/busy got %0b%0b%0b required 100", name, cmd_ready, rsp_valid, busy);
        end
        if (rsp_data !== 16'd0 || rsp_op !== 3'd0 || rsp_err !== 1'b0) begin
            miscompares++;
            $display("FAIL %s_rsp: data/op/err got %0d/%0d/%0b required 0/0/0", name, rsp_data, rsp_op, rsp_err);
        end
        if (alu_a !== 16'd0 || alu_b !== 16'd0 || alu_opcode !== 3'd0) begin
            miscompares++;
            $display("FAIL %s_alu: a/b/op got %0d/%0d/%0d required 0/0/0", name, alu_a, alu_b, alu_opcode);
        end
        if (err_count !== 8'd0) begin
            miscompares++;
            $display("FAIL %s_errcnt: got %0d required 0", name, err_count);
        end
        if (alu_rst !== 1'b1) begin
            miscompares++;
            $display("FAIL %s_alu_rst: got %0b required 1", name, alu_rst);
        end
        if (dut.r_count !== 3'd0) begin
            miscompares++;
            $display("FAIL %s_fifo: occupancy got %0d required 0", name, dut.r_count);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if (alu_rst !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_release_alu_rst: got %0b required 0", alu_rst);
        end
    endtask

    task automatic test_add_latency();
        logic v3, v4;
        push(16'd33, 16'd45, OP_ADD);
        repeat (3) @(negedge clk);
        v3 = rsp_valid;
        @(negedge clk);
        v4 = rsp_valid;
        vectors += 2;
        if (v3 !== 1'b0) begin
            miscompares++;
            $display("FAIL add_early_valid: got %0b required 0", v3);
        end
        if (v4 !== 1'b1) begin
            miscompares++;
            $display("FAIL add_latency_valid: got %0b required 1", v4);
        end
        expect_rsp("add", 16'd78, OP_ADD, 1'b0);
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL add_busy_idle: got %0b required 0", busy);
        end
    endtask

    task automatic test_error();
        int first_valid;
        int rst_cycles;
        first_valid = 0;
        rst_cycles = 0;
        push(16'd9999, 16'd9999, OP_MULT);
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            if (alu_rst) rst_cycles++;
            if (rsp_valid && first_valid == 0) first_valid = i;
        end
        vectors += 2;
        if (first_valid != 5) begin
            miscompares++;
            $display("FAIL err_latency: first valid at %0d required 5", first_valid);
        end
        if (rst_cycles != 1) begin
            miscompares++;
            $display("FAIL err_alu_rst_pulse: cycles got %0d required 1", rst_cycles);
        end
        expect_rsp("mult_err", 16'd0, OP_MULT, 1'b1);
        vectors++;
        if (err_count !== 8'd1) begin
            miscompares++;
            $display("FAIL err_count_one: got %0d required 1", err_count);
        end
        push(16'd1, 16'd1, OP_ADD);
        expect_rsp("add_after_err", 16'd2, OP_ADD, 1'b0);
    endtask

    task automatic test_back_to_back();
        int bad;
        push(16'd64, 16'd30, OP_SUB);
        push(16'd3855, 16'd13107, OP_AND);
        push(16'd3855, 16'd13107, OP_OR);
        push(16'd3855, 16'd13107, OP_XOR);
        push(16'd3855, 16'd0, OP_NOT);
        vectors++;
        if (cmd_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_full_ready: got %0b required 0", cmd_ready);
        end
        bad = 0;
        repeat (4) begin
            @(negedge clk);
            if (rsp_valid !== 1'b1 || rsp_data !== 16'd34 || cmd_ready !== 1'b0) bad++;
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL b2b_stall_stable: bad cycles got %0d required 0 (data %0d)", bad, rsp_data);
        end
        fork
            push(16'd10, 16'd0, OP_SHL);
            begin
                expect_rsp("b2b_sub", 16'd34, OP_SUB, 1'b0);
                expect_rsp("b2b_and", 16'd771, OP_AND, 1'b0);
                expect_rsp("b2b_or", 16'd16191, OP_OR, 1'b0);
                expect_rsp("b2b_xor", 16'd15420, OP_XOR, 1'b0);
                expect_rsp("b2b_not", 16'd61680, OP_NOT, 1'b0);
                expect_rsp("b2b_shl", 16'd20, OP_SHL, 1'b0);
            end
        join
    endtask

    task automatic test_saturation();
        // err_count is 1 on entry; 254 more errors reach 255.
        for (int i = 0; i < 254; i++) begin
            push(16'd9999, 16'd9999, OP_MULT);
            expect_rsp("sat_err", 16'd0, OP_MULT, 1'b1);
        end
        vectors++;
        if (err_count !== 8'd255) begin
            miscompares++;
            $display("FAIL sat_reach: got %0d required 255", err_count);
        end
        for (int i = 0; i < 2; i++) begin
            push(16'd9999, 16'd9999, OP_MULT);
            expect_rsp("sat_err_more", 16'd0, OP_MULT, 1'b1);
        end
        vectors++;
        if (err_count !== 8'd255) begin
            miscompares++;
            $display("FAIL sat_hold: got %0d required 255", err_count);
        end
    endtask

    task automatic test_reset_mid_op();
        int bad;
        push(16'd1, 16'd2, OP_ADD);
        push(16'd3, 16'd4, OP_ADD);
        push(16'd5, 16'd6, OP_ADD);
        push(16'd7, 16'd8, OP_ADD);
        push(16'd9, 16'd10, OP_ADD);
        expect_rsp("mid_first", 16'd3, OP_ADD, 1'b0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        vectors++;
        if (dut.r_count !== 3'd3 || alu_rst !== 1'b0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_precond: occupancy/alu_rst/busy got %0d/%0b/%0b required 3/0/1", dut.r_count, alu_rst, busy);
        end
        rst = 1'b1;
        #1;
        check_reset_values("mid_reset");
        @(negedge clk);
        rst = 1'b0;
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0 || busy !== 1'b0) bad++;
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL mid_no_response: bad cycles got %0d required 0", bad);
        end
        push(16'd5, 16'd6, OP_ADD);
        expect_rsp("after_mid_reset", 16'd11, OP_ADD, 1'b0);
    endtask

    initial begin
        test_reset();
        test_add_latency();
        test_error();
        test_back_to_back();
        test_saturation();
        test_reset_mid_op();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
